// File: rtl/fm_mul_scheduler.sv
// Round-robin scheduler sharing one FP multiplier core among N_REQ requesters.
// A tag pipe matched to MUL_LAT routes each product back to the requester that issued it.
module fm_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_issue,
    input  logic [31:0]          mul_result,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [32*N_REQ-1:0]  rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 busy,
    output logic [15:0]          issue_count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] N_C      = CW'(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    logic [N_REQ-1:0]              outstanding_q, outstanding_d;
    logic [IW-1:0]                 ptr_q, ptr_d;
    logic [31:0]                   mul_a_q, mul_a_d;
    logic [31:0]                   mul_b_q, mul_b_d;
    logic                          issue_q, issue_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [MUL_LAT-1:0]            tag_v_q, tag_v_d;
    logic [MUL_LAT-1:0][IW-1:0]    tag_idx_q, tag_idx_d;
    logic [N_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [32*N_REQ-1:0]           rsp_data_q, rsp_data_d;
    logic                          busy_q, busy_d;
    logic [15:0]                   cnt_q, cnt_d;

    logic                          grant_any;
    logic [IW-1:0]                 grant_idx;
    logic [CW-1:0]                 cand;
    logic [N_REQ-1:0]              eligible;
    logic [N_REQ-1:0]              handshake;

    // Search starts at ptr and wraps; the first eligible index wins.
    always_comb begin
        eligible  = req_valid & ~outstanding_q;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, ptr_q} + CW'(off);
            if (cand >= N_C) begin
                cand = cand - N_C;
            end
            if (!grant_any && eligible[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        req_ready[grant_idx] = grant_any;
    end

    assign handshake = rsp_valid_q & rsp_ready;

    always_comb begin
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        issue_d       = grant_any;
        idx_d         = grant_idx;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q + {15'd0, grant_any};
        outstanding_d = outstanding_q & ~handshake;
        rsp_valid_d   = rsp_valid_q & ~handshake;
        rsp_data_d    = rsp_data_q;
        tag_v_d       = '0;
        tag_idx_d     = '0;

        if (grant_any) begin
            mul_a_d                  = req_a[32*grant_idx +: 32];
            mul_b_d                  = req_b[32*grant_idx +: 32];
            ptr_d                    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            outstanding_d[grant_idx] = 1'b1;
        end

        tag_v_d[0]   = issue_q;
        tag_idx_d[0] = idx_q;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_v_d[s]   = tag_v_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        // The last tag stage lines up with the product currently on mul_result.
        if (tag_v_q[MUL_LAT-1]) begin
            rsp_valid_d[tag_idx_q[MUL_LAT-1]]           = 1'b1;
            rsp_data_d[32*tag_idx_q[MUL_LAT-1] +: 32]   = mul_result;
        end

        busy_d = |outstanding_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            ptr_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            issue_q       <= 1'b0;
            idx_q         <= '0;
            tag_v_q       <= '0;
            tag_idx_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            ptr_q         <= ptr_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            issue_q       <= issue_d;
            idx_q         <= idx_d;
            tag_v_q       <= tag_v_d;
            tag_idx_q     <= tag_idx_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_issue   = issue_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_fm_mul_scheduler.sv
// Bench for fm_mul_scheduler: a small FP-multiply core model drives mul_result, and a
// transaction-level model with due-time queue predicts every output each cycle.
module tb_fm_mul_scheduler;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic [31:0]       mul_a, mul_b;
    logic              mul_issue;
    logic [31:0]       mul_result;
    logic [N-1:0]      rsp_valid;
    logic [32*N-1:0]   rsp_data;
    logic [N-1:0]      rsp_ready = '1;
    logic              busy;
    logic [15:0]       issue_count;

    fm_mul_scheduler #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_issue(mul_issue),
        .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Normal-number single-precision multiply, truncating.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    logic [31:0] core_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) core_pipe[i] = '0;
    always @(posedge clk) begin
        core_pipe[0] <= fpmul(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign mul_result = core_pipe[LAT-1];

    typedef struct {
        int          idx;
        logic [31:0] prod;
        int          due;
    } fl_t;

    fl_t         fq[$];
    int          m_ptr = 0;
    bit [N-1:0]  m_out = '0;
    bit [N-1:0]  m_rv = '0;
    logic [31:0] m_rd [N];
    logic        m_iss = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [15:0] m_cnt = '0;
    int          cyc = 0;

    initial for (int i = 0; i < N; i++) m_rd[i] = '0;

    function automatic int model_grant();
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (req_valid[k] && !m_out[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_p
        int  g;
        fl_t e;
        if (!rst_n) begin
            fq.delete();
            m_ptr = 0; m_out = '0; m_rv = '0; m_iss = 1'b0;
            m_a = '0; m_b = '0; m_cnt = '0; cyc = 0;
            for (int i = 0; i < N; i++) m_rd[i] = '0;
        end else begin
            g = model_grant();
            for (int k = 0; k < N; k++) begin
                if (m_rv[k] && rsp_ready[k]) begin
                    m_rv[k]  = 1'b0;
                    m_out[k] = 1'b0;
                end
            end
            while (fq.size() > 0 && fq[0].due == cyc) begin
                m_rv[fq[0].idx] = 1'b1;
                m_rd[fq[0].idx] = fq[0].prod;
                void'(fq.pop_front());
            end
            if (g >= 0) begin
                m_a      = req_a[g*32 +: 32];
                m_b      = req_b[g*32 +: 32];
                m_iss    = 1'b1;
                m_out[g] = 1'b1;
                m_ptr    = (g + 1) % N;
                m_cnt    = m_cnt + 16'd1;
                e.idx    = g;
                e.prod   = fpmul(m_a, m_b);
                e.due    = cyc + LAT + 1;
                fq.push_back(e);
            end else begin
                m_iss = 1'b0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin : cmp_p
        int g;
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            g = model_grant();
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("mul_issue", 32'(mul_issue), 32'(m_iss));
            chk("mul_a", mul_a, m_a);
            chk("mul_b", mul_b, m_b);
            chk("busy", 32'(busy), 32'(|m_out));
            chk("issue_count", 32'(issue_count), 32'(m_cnt));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            for (int k = 0; k < N; k++)
                chk($sformatf("rsp_data%0d", k), rsp_data[k*32 +: 32], m_rd[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < LAT + 6; i++) step();
    endtask

    initial begin : stim
        logic [31:0] ops_a [N];
        bit done;
        ops_a[0] = 32'h3F800000; ops_a[1] = 32'h40000000;
        ops_a[2] = 32'h40400000; ops_a[3] = 32'h40800000;

        step(); step();
        @(negedge clk);
        chk("reset_issue_count", 32'(issue_count), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_mul_issue", 32'(mul_issue), 32'h0);
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // single op: 2.0 * 3.0
        req_a[31:0] = 32'h40000000;
        req_b[31:0] = 32'h40400000;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_grant_c0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_issue_c1", 32'(mul_issue), 32'h1);
        chk("single_mul_a_c1", mul_a, 32'h40000000);
        step(); step();
        @(negedge clk);
        chk("single_rsp_valid_c3", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data_c3", rsp_data[31:0], 32'h40C00000);
        chk("single_count", 32'(issue_count), 32'h1);
        step();
        @(negedge clk);
        chk("single_rsp_one_wide", 32'(rsp_valid), 32'h0);

        // round robin from ptr 0, all b = 1.5
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = ops_a[i];
            req_b[i*32 +: 32] = 32'h3FC00000;
        end
        req_valid = '1;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            chk($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(1 << c));
            step();
        end
        @(negedge clk);
        chk("rr_regrant0", 32'(req_ready), 32'h1);
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        chk("rr_data1_lit", rsp_data[63:32], 32'h40400000);
        chk("rr_data3_lit", rsp_data[127:96], 32'h40C00000);

        // backpressure on requester 2
        rsp_ready = 4'b1011;
        for (int i = 0; i < 20; i++) begin
            step();
            req_a[0*32 +: 32] = (i % 2 == 0) ? 32'h40A00000 : 32'h3F000000;
            req_a[2*32 +: 32] = 32'h41000000;
        end
        @(negedge clk);
        chk("bp_ready2_low", 32'(req_ready[2]), 32'h0);
        chk("bp_rsp2_held", rsp_data[95:64], 32'h40900000);
        rsp_ready = '1;
        for (int i = 0; i < 12; i++) step();
        @(negedge clk);
        chk("bp_rsp2_new", rsp_data[95:64], 32'h41400000);

        // pointer skip: ptr=2, requesters 3 and 1 pending
        drain();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        drain();
        req_valid = 4'b1010;
        @(negedge clk);
        chk("skip_grant3", 32'(req_ready), 32'h8);
        step();
        @(negedge clk);
        chk("skip_grant1", 32'(req_ready), 32'h2);
        step();
        drain();

        // reset mid-flight
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_issue", 32'(mul_issue), 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst_count", 32'(issue_count), 32'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 6; i++) step();
        @(negedge clk);
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);

        // counter wrap
        req_valid = '1;
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            step();
            if (issue_count == 16'hFFFF) done = 1'b1;
        end
        req_valid = '0;
        chk("wrap_reached", 32'(done), 32'h1);
        drain();
        @(negedge clk);
        chk("wrap_ffff", 32'(issue_count), 32'h0000FFFF);
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("wrap_zero", 32'(issue_count), 32'h0);
        drain();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
